// File: rtl/ram_port_arbiter.sv
// Two-port arbiter for the single-port ram2: CPU path (A) and DMA/loader (B); ARB_FIXED_PRIO_EN makes A win ties.
// Latency: write done 2 clocks after the req-sampling edge, read done 2+RD_LAT clocks after it.
// Backpressure: requesters hold req until done; a losing port is re-arbitrated in the next IDLE cycle.
module ram_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              last_served;
  logic [CNT_W-1:0]  cnt;
  logic              win_b;
  logic              wait_last;

  // owner/last_served encoding: 0 = port A, 1 = port B
`ifdef ARB_FIXED_PRIO_EN
  assign win_b = b_req & ~a_req;
`else
  assign win_b = b_req & (~a_req | ~last_served);
`endif

  assign wait_last = (cnt == '0);
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    a_done    = 1'b0;
    b_done    = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (a_req | b_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        ram_we    = lat_we;
        ram_re    = ~lat_we;
        a_gnt     = ~owner;
        b_gnt     = owner;
        state_nxt = lat_we ? RESP : WAIT;
      end
      WAIT: begin
        if (wait_last) state_nxt = RESP;
      end
      RESP: begin
        a_done    = ~owner;
        b_done    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      cnt         <= '0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            owner       <= win_b;
            last_served <= win_b;
            lat_we      <= win_b ? b_we    : a_we;
            lat_addr    <= win_b ? b_addr  : a_addr;
            lat_wdata   <= win_b ? b_wdata : a_wdata;
          end
        end
        ACCESS: cnt <= CNT_W'(RD_LAT - 1);
        WAIT: begin
          if (wait_last) begin
            if (owner) b_rdata <= ram_rdata;
            else       a_rdata <= ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised bench for ram_port_arbiter: behavioural RAM with RD_LAT read pipe plus a transaction-level timing/data model.
module tb_ram_port_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic              a_gnt, a_done, b_gnt, b_done;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_we, ram_re, busy, owner;

  ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] init_pat(input logic [ADDR_W-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // ram2 stand-in: unwritten words read back as init_pat(addr)
  logic [DATA_W-1:0] mem [256];
  bit                wr_valid [256];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr]      <= ram_wdata;
      wr_valid[ram_addr] <= 1'b1;
    end
    rd_pipe[0] <= ram_re ? (wr_valid[ram_addr] ? mem[ram_addr] : init_pat(ram_addr)) : rd_pipe[0];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DATA_W-1:0] ref_mem [256];
  int                ref_last = 1;
  logic [DATA_W-1:0] exp_rdata [2];

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_round(input bit ra, input bit wa, input logic [7:0] aa, input logic [31:0] da,
                           input bit rb, input bit wb, input logic [7:0] ba, input logic [31:0] db);
    bit                act[2], pwe[2];
    logic [7:0]        paddr[2];
    logic [31:0]       pdata[2], exp_rd[2];
    int                g[2], d[2], order[2], n, last;
    bit                eg[2], ed[2], ewe, ere, ebusy, eown;
    act = '{ra, rb}; pwe = '{wa, wb}; paddr = '{aa, ba}; pdata = '{da, db};
    g = '{0, 0}; d = '{0, 0};
    if (ra && rb) begin
`ifdef ARB_FIXED_PRIO_EN
      order[0] = 0;
`else
      order[0] = (ref_last == 1) ? 0 : 1;
`endif
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = ra ? 0 : 1;
      order[1] = -1;
      n = 1;
    end
    last = -1;
    for (int i = 0; i < n; i++) begin
      int p;
      p = order[i];
      g[p] = (i == 0) ? 1 : d[order[0]] + 2;
      d[p] = g[p] + 1 + (pwe[p] ? 0 : RD_LAT);
      if (pwe[p]) ref_mem[paddr[p]] = pdata[p];
      else        exp_rd[p] = ref_mem[paddr[p]];
      last = d[p];
      ref_last = p;
    end
    a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
    b_req = rb; b_we = wb; b_addr = ba; b_wdata = db;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clock);
      ewe = 1'b0; ere = 1'b0;
      for (int p = 0; p < 2; p++) begin
        eg[p] = act[p] && (k == g[p]);
        ed[p] = act[p] && (k == d[p]);
        if (eg[p]) begin ewe |= pwe[p]; ere |= !pwe[p]; end
        if (ed[p] && !pwe[p]) exp_rdata[p] = exp_rd[p];
      end
      ebusy = (k <= d[order[0]]) || (n == 2 && k >= g[order[1]] && k <= d[order[1]]);
      eown  = (n == 2 && k >= g[order[1]]) ? order[1][0] : order[0][0];
      check($sformatf("ctl k%0d", k),
            64'({a_gnt, b_gnt, a_done, b_done, ram_we, ram_re, busy, owner}),
            64'({eg[0], eg[1], ed[0], ed[1], ewe, ere, ebusy, eown}));
      check("a_rdata", 64'(a_rdata), 64'(exp_rdata[0]));
      check("b_rdata", 64'(b_rdata), 64'(exp_rdata[1]));
      for (int p = 0; p < 2; p++) begin
        if (act[p] && k >= g[p] && k <= d[p]) check("ram_addr", 64'(ram_addr), 64'(paddr[p]));
        if (eg[p] && pwe[p]) check("ram_wdata", 64'(ram_wdata), 64'(pdata[p]));
        // a dropped req after grant must not abort; done still expected
        if (ed[p] || (eg[p] && $urandom_range(0, 3) == 0)) begin
          if (p == 0) a_req = 1'b0;
          else        b_req = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(8'(i));
    exp_rdata = '{32'h0, 32'h0};
    repeat (2) @(negedge clock);
    check("rst_ctl", 64'({a_gnt, b_gnt, a_done, b_done, ram_we, ram_re, busy, owner}), 64'(0));
    check("rst_ram_addr", 64'(ram_addr), 64'(0));
    check("rst_ram_wdata", 64'(ram_wdata), 64'(0));
    check("rst_a_rdata", 64'(a_rdata), 64'(0));
    check("rst_b_rdata", 64'(b_rdata), 64'(0));
    reset = 1'b1;

    // simultaneous reads from reset: A then B, then alternating
    run_round(1, 0, 8'h30, 32'h0, 1, 0, 8'h31, 32'h0);
    run_round(1, 0, 8'h32, 32'h0, 1, 0, 8'h33, 32'h0);
    run_round(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0);
    run_round(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    run_round(1, 0, 8'h20, 32'h0, 1, 1, 8'h20, 32'h55);
    run_round(1, 0, 8'h20, 32'h0, 1, 1, 8'h20, 32'h66);

    for (int r = 0; r < 150; r++) begin
      int  sel, gap;
      logic [7:0] xa, xb;
      sel = $urandom_range(1, 3);
      xa  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      xb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      run_round(sel[0], 1'($urandom_range(0, 1)), xa, $urandom,
                sel[1], 1'($urandom_range(0, 1)), xb, $urandom);
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        @(negedge clock);
        check("idle_ctl", 64'({a_gnt, b_gnt, a_done, b_done, ram_we, ram_re, busy}), 64'(0));
      end
    end

    // B read of a known word so b_rdata is non-zero before the mid-WAIT reset
    run_round(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
    check("pre_rst_b_rdata_nz", 64'(b_rdata == '0), 64'(0));

    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h21;
    @(negedge clock);
    check("mw_access", 64'({b_gnt, ram_re}), 64'(2'b11));
    @(negedge clock);
    check("mw_wait", 64'({busy, owner, ram_re, ram_we}), 64'(4'b1100));
    #2 reset = 1'b0;
    #1;
    check("mw_rst_ctl", 64'({busy, owner, ram_we, ram_re, b_gnt, b_done}), 64'(0));
    check("mw_rst_addr", 64'(ram_addr), 64'(0));
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      check("mw_no_done", 64'({b_done, busy}), 64'(0));
    end
    b_req = 1'b0;
    reset = 1'b1;
    ref_last = 1;
    exp_rdata = '{32'h0, 32'h0};
    check("mw_b_rdata", 64'(b_rdata), 64'(0));
    check("mw_a_rdata", 64'(a_rdata), 64'(0));

    // arbitration restarts with A winning the first tie
    run_round(1, 0, 8'h10, 32'h0, 1, 0, 8'h21, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
